// File: rtl/cplx_dot_acc_stream.sv
// Streaming complex dot-product accumulator: sum of a[k]*b[k] or a[k]*conj(b[k]) over LANES pairs per beat.
// Define CPLX_SAT_EN for saturating accumulation with a sticky ovf flag; otherwise accumulation wraps and ovf stays 0.
module cplx_dot_acc_stream #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    conj_mode,
  input  logic [CNT_W-1:0]        num_beats,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] a_real_vec,
  input  logic [LANES*DATA_W-1:0] a_imag_vec,
  input  logic [LANES*DATA_W-1:0] b_real_vec,
  input  logic [LANES*DATA_W-1:0] b_imag_vec,
  output logic signed [ACC_W-1:0] z_real,
  output logic signed [ACC_W-1:0] z_imag,
  output logic                    done,
  output logic                    busy,
  output logic                    ovf
);

  localparam int PROD_W = 2*DATA_W + 1;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             conj_q, conj_d;
  logic             vld_p1, vld_p2, vld_p3;
  logic             ovf_q;
  logic             start_ok, accept;

  logic signed [PROD_W-1:0] lane_re_d [LANES];
  logic signed [PROD_W-1:0] lane_im_d [LANES];
  logic signed [PROD_W-1:0] re_p1 [LANES];
  logic signed [PROD_W-1:0] im_p1 [LANES];
  logic signed [SUM_W-1:0]  sum_re_d, sum_im_d;
  logic signed [SUM_W-1:0]  sum_re_p2, sum_im_p2;
  logic signed [ACC_W-1:0]  acc_re_p3, acc_im_p3;
  logic [ACC_W:0]           add_re, add_im;

  // Returns {overflow, sum}; overflow can only be flagged in the saturating build.
  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    s = a + b;
`ifdef CPLX_SAT_EN
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
      if (a[ACC_W-1])
        return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      else
        return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    return {1'b0, s};
  endfunction

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign in_ready = (state_q == S_RUN) && (rem_q != '0);
  assign accept   = in_valid && in_ready;
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign ovf      = ovf_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    conj_d  = conj_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          rem_d   = num_beats;
          conj_d  = conj_mode;
          state_d = (num_beats == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!vld_p1 && !vld_p2 && !vld_p3) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 0 -> 1: per-lane complex products, widened by one bit for the add/subtract
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [DATA_W-1:0]   ar, ai, br, bi;
    logic signed [2*DATA_W-1:0] rr, ii, ir, ri;
    assign ar = a_real_vec[DATA_W*j +: DATA_W];
    assign ai = a_imag_vec[DATA_W*j +: DATA_W];
    assign br = b_real_vec[DATA_W*j +: DATA_W];
    assign bi = b_imag_vec[DATA_W*j +: DATA_W];
    assign rr = ar * br;
    assign ii = ai * bi;
    assign ir = ai * br;
    assign ri = ar * bi;
    assign lane_re_d[j] = conj_q ? PROD_W'(rr) + PROD_W'(ii) : PROD_W'(rr) - PROD_W'(ii);
    assign lane_im_d[j] = conj_q ? PROD_W'(ir) - PROD_W'(ri) : PROD_W'(ir) + PROD_W'(ri);
  end

  // Stage 1 -> 2: lane reduction
  always_comb begin
    sum_re_d = '0;
    sum_im_d = '0;
    for (int j = 0; j < LANES; j++) begin
      sum_re_d = sum_re_d + SUM_W'(re_p1[j]);
      sum_im_d = sum_im_d + SUM_W'(im_p1[j]);
    end
  end

  // Stage 2 -> 3: accumulation
  assign add_re = acc_add(acc_re_p3, ACC_W'(sum_re_p2));
  assign add_im = acc_add(acc_im_p3, ACC_W'(sum_im_p2));

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < LANES; j++) begin
        re_p1[j] <= lane_re_d[j];
        im_p1[j] <= lane_im_d[j];
      end
    end
    if (vld_p1) begin
      sum_re_p2 <= sum_re_d;
      sum_im_p2 <= sum_im_d;
    end
    if (start_ok) begin
      acc_re_p3 <= '0;
      acc_im_p3 <= '0;
    end else if (vld_p2) begin
      acc_re_p3 <= add_re[ACC_W-1:0];
      acc_im_p3 <= add_im[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      conj_q  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      ovf_q   <= 1'b0;
      z_real  <= '0;
      z_imag  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      conj_q  <= conj_d;
      vld_p1  <= accept;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      if (start_ok) begin
        ovf_q  <= 1'b0;
        z_real <= '0;
        z_imag <= '0;
      end else begin
        if (vld_p2 && (add_re[ACC_W] || add_im[ACC_W])) ovf_q <= 1'b1;
        // Result is published only when the job completes, then held.
        if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
          z_real <= acc_re_p3;
          z_imag <= acc_im_p3;
        end
      end
    end
  end

endmodule

// File: tb/tb_cplx_dot_acc_stream.sv
// Scoreboard bench for cplx_dot_acc_stream: a 48-bit accumulator instance and a 32-bit one for the overflow case.
module tb_cplx_dot_acc_stream;
  localparam int DW = 16;
  localparam int LN = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start48, start32, conj_mode, in_valid;
  logic [CW-1:0] num_beats;
  logic [LN*DW-1:0] a_re_v, a_im_v, b_re_v, b_im_v;
  logic rdy48, done48, busy48, ovf48;
  logic rdy32, done32, busy32, ovf32;
  logic signed [47:0] zr48, zi48;
  logic signed [31:0] zr32, zi32;

  cplx_dot_acc_stream #(.DATA_W(DW), .LANES(LN), .ACC_W(48), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start48), .conj_mode(conj_mode), .num_beats(num_beats),
    .in_valid(in_valid), .in_ready(rdy48), .a_real_vec(a_re_v), .a_imag_vec(a_im_v),
    .b_real_vec(b_re_v), .b_imag_vec(b_im_v), .z_real(zr48), .z_imag(zi48),
    .done(done48), .busy(busy48), .ovf(ovf48));

  cplx_dot_acc_stream #(.DATA_W(DW), .LANES(LN), .ACC_W(32), .CNT_W(CW)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .conj_mode(conj_mode), .num_beats(num_beats),
    .in_valid(in_valid), .in_ready(rdy32), .a_real_vec(a_re_v), .a_imag_vec(a_im_v),
    .b_real_vec(b_re_v), .b_imag_vec(b_im_v), .z_real(zr32), .z_imag(zi32),
    .done(done32), .busy(busy32), .ovf(ovf32));

  typedef struct { longint re; longint im; bit ov; bit zero; int sedge; } exp_t;
  exp_t q48[$];
  exp_t q32[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int last48 = 0, last32 = 0, ndone48 = 0, ndone32 = 0, njob48 = 0, njob32 = 0;
  bit pd48 = 1'b0, pd32 = 1'b0;
  int ar[LN], ai[LN], br[LN], bi[LN];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic longint beat_re(input bit conj);
    longint s = 0;
    for (int j = 0; j < LN; j++)
      s += conj ? longint'(ar[j]) * br[j] + longint'(ai[j]) * bi[j]
                : longint'(ar[j]) * br[j] - longint'(ai[j]) * bi[j];
    return s;
  endfunction

  function automatic longint beat_im(input bit conj);
    longint s = 0;
    for (int j = 0; j < LN; j++)
      s += conj ? longint'(ai[j]) * br[j] - longint'(ar[j]) * bi[j]
                : longint'(ai[j]) * br[j] + longint'(ar[j]) * bi[j];
    return s;
  endfunction

  function automatic longint fitw(input longint v, input int w, output bit o);
    longint mx, mn, m;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    o = 1'b0;
`ifdef CPLX_SAT_EN
    if (v > mx) begin o = 1'b1; return mx; end
    if (v < mn) begin o = 1'b1; return mn; end
`endif
    m = v & ((longint'(1) <<< w) - 1);
    if (m > mx) m = m - (longint'(1) <<< w);
    return m;
  endfunction

  always @(negedge clk) begin : mon48
    exp_t e;
    if (done48) begin
      chk("done48_pulse", pd48, 0);
      if (q48.size() == 0) chk("done48_unexpected", 1, 0);
      else begin
        e = q48.pop_front();
        chk("zre48", zr48, e.re);
        chk("zim48", zi48, e.im);
        chk("ovf48", ovf48, e.ov);
        chk("lat48", cyc, e.zero ? e.sedge : last48 + 4);
      end
      ndone48++;
    end
    pd48 = done48;
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32) begin
      chk("done32_pulse", pd32, 0);
      if (q32.size() == 0) chk("done32_unexpected", 1, 0);
      else begin
        e = q32.pop_front();
        chk("zre32", zr32, e.re);
        chk("zim32", zi32, e.im);
        chk("ovf32", ovf32, e.ov);
        chk("lat32", cyc, e.zero ? e.sedge : last32 + 4);
      end
      ndone32++;
    end
    pd32 = done32;
  end

  task automatic push(input bit sel, input exp_t e);
    if (sel) begin q32.push_back(e); njob32++; end
    else begin q48.push_back(e); njob48++; end
  endtask

  task automatic load_vecs();
    for (int j = 0; j < LN; j++) begin
      a_re_v[DW*j +: DW] = DW'(ar[j]);
      a_im_v[DW*j +: DW] = DW'(ai[j]);
      b_re_v[DW*j +: DW] = DW'(br[j]);
      b_im_v[DW*j +: DW] = DW'(bi[j]);
    end
  endtask

  task automatic pulse_start(input bit sel, input int nb, input bit conj);
    num_beats = CW'(nb);
    conj_mode = conj;
    if (sel) start32 = 1'b1; else start48 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    start48 = 1'b0;
  endtask

  task automatic send_beat(input bit sel);
    bit ok = 1'b0;
    load_vecs();
    in_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (sel ? rdy32 : rdy48) begin
        ok = 1'b1;
        if (sel) last32 = cyc + 1; else last48 = cyc + 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  task automatic run_job(input bit sel, input int nb, input bit conj, input bit rnd, input int gap);
    longint are = 0, aim = 0;
    bit ov = 1'b0, o1, o2;
    int w;
    exp_t e;
    w = sel ? 32 : 48;
    if (nb == 0) begin
      e.re = 0; e.im = 0; e.ov = 1'b0; e.zero = 1'b1; e.sedge = cyc + 1;
      push(sel, e);
    end
    pulse_start(sel, nb, conj);
    if (nb > 0) chk("busy_after_start", sel ? busy32 : busy48, 1);
    for (int b = 0; b < nb; b++) begin
      if (b > 0) repeat (gap) @(negedge clk);
      if (rnd) begin
        for (int j = 0; j < LN; j++) begin
          ar[j] = int'($urandom_range(65535)) - 32768;
          ai[j] = int'($urandom_range(65535)) - 32768;
          br[j] = int'($urandom_range(65535)) - 32768;
          bi[j] = int'($urandom_range(65535)) - 32768;
        end
      end
      are = fitw(are + beat_re(conj), w, o1);
      aim = fitw(aim + beat_im(conj), w, o2);
      ov = ov | o1 | o2;
      send_beat(sel);
    end
    if (nb > 0) begin
      e.re = are; e.im = aim; e.ov = ov; e.zero = 1'b0; e.sedge = 0;
      push(sel, e);
      chk("rdy_after_last", sel ? rdy32 : rdy48, 0);
    end
  endtask

  task automatic wait_idle(input bit sel);
    int t = 0;
    while (((sel ? q32.size() : q48.size()) != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic set_t1();
    ar[0] = 5;  ai[0] = 20; ar[1] = 20; ai[1] = 5;
    br[0] = -5; bi[0] = -5; br[1] = -5; bi[1] = -5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; start48 = 1'b0; start32 = 1'b0; conj_mode = 1'b0; in_valid = 1'b0;
    num_beats = '0; a_re_v = '0; a_im_v = '0; b_re_v = '0; b_im_v = '0;
    repeat (3) @(negedge clk);
    chk("rst_zre", zr48, 0);
    chk("rst_zim", zi48, 0);
    chk("rst_done", done48, 0);
    chk("rst_busy", busy48, 0);
    chk("rst_rdy", rdy48, 0);
    chk("rst_ovf", ovf48, 0);
    chk("rst_zre32", zr32, 0);
    rst = 1'b0;
    @(negedge clk);

    set_t1();
    run_job(0, 1, 1'b0, 1'b0, 0);
    wait_idle(0);
    chk("t1_zre", zr48, 0);
    chk("t1_zim", zi48, -250);

    run_job(0, 1, 1'b1, 1'b0, 0);
    wait_idle(0);
    chk("t2_zre", zr48, -250);
    chk("t2_zim", zi48, 0);

    run_job(0, 3, 1'b0, 1'b0, 2);
    wait_idle(0);
    chk("t3_zim", zi48, -750);

    run_job(0, 0, 1'b0, 1'b0, 0);
    for (int t = 0; t < 3; t++) chk("t4_rdy_zero", rdy48, 0);
    for (int t = 0; t < 3; t++) begin chk("t4_rdy_zero", rdy48, 0); @(negedge clk); end
    chk("t4_zre", zr48, 0);

    pulse_start(0, 2, 1'b0);
    send_beat(0);
    pulse_start(0, 5, 1'b1);
    send_beat(0);
    e.re = 0; e.im = -500; e.ov = 1'b0; e.zero = 1'b0; e.sedge = 0;
    push(0, e);
    wait_idle(0);

    pulse_start(0, 3, 1'b0);
    send_beat(0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", busy48, 0);
    chk("t5_rdy", rdy48, 0);
    chk("t5_zre", zr48, 0);
    chk("t5_zim", zi48, 0);
    chk("t5_done", done48, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_job(0, 4, 1'b1, 1'b1, 1);
    wait_idle(0);
    run_job(0, 5, 1'b0, 1'b1, 0);
    wait_idle(0);

    for (int j = 0; j < LN; j++) begin
      ar[j] = 32767; ai[j] = 0; br[j] = 32767; bi[j] = 0;
    end
    run_job(1, 2, 1'b0, 1'b0, 0);
    wait_idle(1);
`ifdef CPLX_SAT_EN
    chk("t6_zre32", zr32, 2147483647);
    chk("t6_ovf32", ovf32, 1);
`else
    chk("t6_zre32", zr32, -262140);
    chk("t6_ovf32", ovf32, 0);
`endif
    run_job(1, 6, 1'b0, 1'b1, 0);
    wait_idle(1);

    repeat (6) @(negedge clk);
    chk("ndone48", ndone48, njob48);
    chk("ndone32", ndone32, njob32);
    chk("q48_left", q48.size(), 0);
    chk("q32_left", q32.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
